// File: rtl/mc_cpu_pkg.sv
// rtl/mc_cpu_pkg.sv - opcodes, ALU codes, FSM states and helpers for the multi-cycle R/I/J core
package mc_cpu_pkg;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_XOR  = 3'b010,
    ALU_NOR  = 3'b011,
    ALU_ADD  = 3'b100,
    ALU_SUB  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_SLL  = 3'b111
  } alu_op_t;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd5
  } state_t;

  // Instruction class drives the EX/MEM/WB path choice.
  typedef enum logic [2:0] {
    C_ALU = 3'd0,
    C_LW  = 3'd1,
    C_SW  = 3'd2,
    C_BEQ = 3'd3,
    C_BNE = 3'd4,
    C_J   = 3'd5,
    C_JAL = 3'd6,
    C_JR  = 3'd7
  } iclass_t;

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
    return sgn ? {{16{v[15]}}, v} : {16'h0000, v};
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit ALU with zero and signed-overflow flags
module alu
  import mc_cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] f,
  output logic        zf,
  output logic        of
);

  always_comb begin
    f  = '0;
    of = 1'b0;
    case (op)
      ALU_AND:  f = a & b;
      ALU_OR:   f = a | b;
      ALU_XOR:  f = a ^ b;
      ALU_NOR:  f = ~(a | b);
      ALU_ADD: begin
        f  = a + b;
        of = (a[31] == b[31]) && (f[31] != a[31]);
      end
      ALU_SUB: begin
        f  = a - b;
        of = (a[31] != b[31]) && (f[31] != a[31]);
      end
      ALU_SLTU: f = {31'b0, (a < b)};
      ALU_SLL:  f = b << a[4:0];
      default:  f = '0;
    endcase
    zf = (f == 32'h0);
  end

endmodule

// File: rtl/regs.sv
// rtl/regs.sv - 32x32 register file, two async read ports, one clocked write port
module regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] rf [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      rf[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'h0 : rf[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'h0 : rf[ra2];

endmodule

// File: rtl/rij_decode.sv
// rtl/rij_decode.sv - combinational opcode/func decode into datapath controls
module rij_decode
  import mc_cpu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fn,
  output logic [2:0] alu_op,
  output logic       imm_s,
  output logic       rt_imm_s,
  output logic       w_r_s,
  output logic       wr_data_s,
  output logic [2:0] iclass,
  output logic       of_en,
  output logic       sh_s,
  output logic       illegal
);

  // imm_s: sign-extend; rt_imm_s: B operand is the immediate; w_r_s: write rd.
  always_comb begin
    alu_op    = ALU_ADD;
    imm_s     = 1'b1;
    rt_imm_s  = 1'b1;
    w_r_s     = 1'b0;
    wr_data_s = 1'b0;
    iclass    = C_ALU;
    of_en     = 1'b0;
    sh_s      = 1'b0;
    illegal   = 1'b0;
    case (op)
      OP_R: begin
        rt_imm_s = 1'b0;
        w_r_s    = 1'b1;
        case (fn)
          FN_ADD:  begin alu_op = ALU_ADD; of_en = 1'b1; end
          FN_SUB:  begin alu_op = ALU_SUB; of_en = 1'b1; end
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_SLL:  begin alu_op = ALU_SLL; sh_s = 1'b1; end
          FN_JR:   iclass = C_JR;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI:  of_en = 1'b1;
      OP_ANDI:  begin alu_op = ALU_AND;  imm_s = 1'b0; end
      OP_XORI:  begin alu_op = ALU_XOR;  imm_s = 1'b0; end
      OP_SLTIU: begin alu_op = ALU_SLTU; imm_s = 1'b0; end
      OP_LW:    begin iclass = C_LW; wr_data_s = 1'b1; end
      OP_SW:    iclass = C_SW;
      OP_BEQ:   begin iclass = C_BEQ; alu_op = ALU_SUB; rt_imm_s = 1'b0; end
      OP_BNE:   begin iclass = C_BNE; alu_op = ALU_SUB; rt_imm_s = 1'b0; end
      OP_J:     iclass = C_J;
      OP_JAL:   iclass = C_JAL;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_rij_cpu.sv
// rtl/mc_rij_cpu.sv - multi-cycle IF/ID/EX/MEM/WB core with handshaked instruction/data memories
module mc_rij_cpu
  import mc_cpu_pkg::*;
#(
  parameter int          IMEM_AW  = 6,
  parameter int          DMEM_AW  = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_ready,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic [31:0]        dmem_rdata,
  input  logic               dmem_ready,
  output logic [31:0]        PC,
  output logic               FR_ZF,
  output logic               FR_OF,
  output logic [31:0]        ALU_F,
  output logic               inst_done,
  output logic               illegal
);

  state_t      state;
  logic [31:0] ir, a_q, b_q, imm_q, mdr;

  logic [2:0]  alu_op, iclass;
  logic        imm_s, rt_imm_s, w_r_s, wr_data_s, of_en, sh_s, dec_illegal;
  logic [31:0] rf_rd1, rf_rd2, rf_wd, alu_a, alu_b, alu_f;
  logic [4:0]  rf_wa;
  logic        rf_we, alu_zf, alu_of;

  rij_decode u_dec (
    .op        (ir[31:26]),
    .fn        (ir[5:0]),
    .alu_op    (alu_op),
    .imm_s     (imm_s),
    .rt_imm_s  (rt_imm_s),
    .w_r_s     (w_r_s),
    .wr_data_s (wr_data_s),
    .iclass    (iclass),
    .of_en     (of_en),
    .sh_s      (sh_s),
    .illegal   (dec_illegal)
  );

  regs u_regs (
    .clk (clk),
    .rst (rst),
    .we  (rf_we),
    .wa  (rf_wa),
    .wd  (rf_wd),
    .ra1 (ir[25:21]),
    .ra2 (ir[20:16]),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2)
  );

  assign alu_a = sh_s ? {27'b0, ir[10:6]} : a_q;
  assign alu_b = rt_imm_s ? imm_q : b_q;

  alu u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .f  (alu_f),
    .zf (alu_zf),
    .of (alu_of)
  );

  assign imem_addr  = PC[IMEM_AW+1:2];
  assign dmem_addr  = ALU_F[DMEM_AW+1:2];
  assign dmem_wdata = b_q;

  // FR_OF was refreshed in EX for add/sub/addi, so it marks an overflowed result here.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = ir[20:16];
    rf_wd = ALU_F;
    if (state == S_WB) begin
      rf_we = !(of_en && FR_OF);
      rf_wa = w_r_s ? ir[15:11] : ir[20:16];
      rf_wd = wr_data_s ? mdr : ALU_F;
    end else if ((state == S_EX) && (iclass == C_JAL)) begin
      rf_we = 1'b1;
      rf_wa = 5'd31;
      rf_wd = PC;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IF;
      PC        <= RESET_PC;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      mdr       <= '0;
      ALU_F     <= '0;
      FR_ZF     <= 1'b0;
      FR_OF     <= 1'b0;
      illegal   <= 1'b0;
      inst_done <= 1'b0;
      imem_req  <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
    end else begin
      inst_done <= 1'b0;
      case (state)
        S_IF: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ready) begin
            ir       <= imem_rdata;
            PC       <= PC + 32'd4;
            imem_req <= 1'b0;
            state    <= S_ID;
          end
        end
        S_ID: begin
          a_q   <= rf_rd1;
          b_q   <= rf_rd2;
          imm_q <= ext16(ir[15:0], imm_s);
          if (dec_illegal) begin
            illegal <= 1'b1;
            state   <= S_ERR;
          end else begin
            state <= S_EX;
          end
        end
        S_EX: begin
          ALU_F <= alu_f;
          if ((iclass == C_ALU) || (iclass == C_BEQ) || (iclass == C_BNE)) FR_ZF <= alu_zf;
          if (of_en) FR_OF <= alu_of;
          case (iclass)
            C_LW, C_SW: begin
              dmem_req <= 1'b1;
              dmem_we  <= (iclass == C_SW);
              state    <= S_MEM;
            end
            C_ALU: state <= S_WB;
            default: begin
              // Branches and jumps retire straight out of EX.
              if ((iclass == C_BEQ && alu_zf) || (iclass == C_BNE && !alu_zf))
                PC <= PC + {imm_q[29:0], 2'b00};
              else if (iclass == C_J || iclass == C_JAL)
                PC <= {PC[31:28], ir[25:0], 2'b00};
              else if (iclass == C_JR)
                PC <= a_q;
              inst_done <= 1'b1;
              imem_req  <= 1'b1;
              state     <= S_IF;
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (iclass == C_SW) begin
              inst_done <= 1'b1;
              imem_req  <= 1'b1;
              state     <= S_IF;
            end else begin
              mdr   <= dmem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          inst_done <= 1'b1;
          imem_req  <= 1'b1;
          state     <= S_IF;
        end
        default: state <= S_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_rij_cpu.sv
// tb/tb_mc_rij_cpu.sv - directed self-checking bench for mc_rij_cpu
module tb_mc_rij_cpu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ready;
  logic [5:0]  imem_addr, dmem_addr;
  logic [31:0] imem_rdata, dmem_rdata, dmem_wdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] PC, ALU_F;
  logic        FR_ZF, FR_OF, inst_done, illegal;

  mc_rij_cpu dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .PC         (PC),
    .FR_ZF      (FR_ZF),
    .FR_OF      (FR_OF),
    .ALU_F      (ALU_F),
    .inst_done  (inst_done),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cycle  = 0;
  always @(posedge clk) cycle++;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  int i_wait = 0, d_wait = 0, i_cnt = 0, d_cnt = 0;
  int stab_err = 0, i_req_cycles = 0, d_req_cycles = 0;
  logic        i_hold = 1'b0, d_hold = 1'b0;
  logic [5:0]  i_addr_h, d_last_addr;
  logic [38:0] d_h;

  // Memory responders: ready after a programmable number of req cycles.
  always @(negedge clk) begin
    if (imem_req) begin
      if (i_hold && (imem_addr !== i_addr_h)) stab_err++;
      i_hold = 1'b1; i_addr_h = imem_addr; i_req_cycles++;
      if (i_cnt >= i_wait) begin
        imem_ready = 1'b1; imem_rdata = imem[imem_addr]; i_cnt = 0; i_hold = 1'b0;
      end else begin
        imem_ready = 1'b0; i_cnt++;
      end
    end else begin
      imem_ready = 1'b0; i_cnt = 0; i_hold = 1'b0;
    end
    if (dmem_req) begin
      if (d_hold && ({dmem_we, dmem_addr, dmem_wdata} !== d_h)) stab_err++;
      d_hold = 1'b1; d_h = {dmem_we, dmem_addr, dmem_wdata}; d_req_cycles++;
      d_last_addr = dmem_addr;
      if (d_cnt >= d_wait) begin
        dmem_ready = 1'b1; d_cnt = 0; d_hold = 1'b0;
        if (dmem_we) dmem[dmem_addr] = dmem_wdata;
        else dmem_rdata = dmem[dmem_addr];
      end else begin
        dmem_ready = 1'b0; d_cnt++;
      end
    end else begin
      dmem_ready = 1'b0; d_cnt = 0; d_hold = 1'b0;
    end
  end

  function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_done(input int n, input string tag);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (inst_done) got++;
    end
    chk(tag, got, n);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin imem[i] = 32'h0; dmem[i] = 32'h0; end
  endtask

  int c0;

  initial begin
    rst = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = '0; dmem_rdata = '0;
    clear_mem();
    // Zero-wait ALU run
    imem[0] = i_ins(6'h08, 0, 1, 16'd5);
    imem[1] = i_ins(6'h08, 0, 2, 16'hFFFD);
    imem[2] = r_ins(1, 2, 3, 0, 6'h20);
    imem[3] = j_ins(6'h02, 26'd3);
    repeat (2) @(negedge clk);
    chk("rst_pc", PC, 32'h0);
    chk("rst_ctl", {imem_req, dmem_req, dmem_we, FR_ZF, FR_OF, illegal, inst_done}, 32'h0);
    chk("rst_aluf", ALU_F, 32'h0);
    rst = 1'b1;
    for (int k = 0; k < 20 && !imem_req; k++) @(negedge clk);
    chk("t1_req", imem_req, 1);
    c0 = cycle;
    wait_done(3, "t1_done");
    chk("t1_cycles", cycle - c0, 12);
    chk("t1_pc", PC, 32'd12);
    chk("t1_r3", dut.u_regs.rf[3], 32'd2);
    chk("t1_of", FR_OF, 0);
    chk("t1_aluf", ALU_F, 32'd2);

    // Overflow suppression and flags
    rst = 1'b0;
    clear_mem();
    imem[0] = i_ins(6'h08, 0, 1, 16'd1);
    imem[1] = r_ins(0, 1, 1, 31, 6'h00);
    imem[2] = r_ins(1, 0, 1, 0, 6'h27);
    imem[3] = i_ins(6'h08, 0, 4, 16'd9);
    imem[4] = r_ins(1, 1, 4, 0, 6'h20);
    imem[5] = i_ins(6'h0E, 0, 5, 16'd7);
    imem[6] = r_ins(4, 4, 6, 0, 6'h22);
    imem[7] = i_ins(6'h0B, 4, 7, 16'd10);
    imem[8] = j_ins(6'h02, 26'd8);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_done(6, "t2_done6");
    chk("t2_r1", dut.u_regs.rf[1], 32'h7FFF_FFFF);
    chk("t2_r4", dut.u_regs.rf[4], 32'd9);
    chk("t2_of", FR_OF, 1);
    chk("t2_r5", dut.u_regs.rf[5], 32'd7);
    wait_done(1, "t2_done7");
    chk("t2_zf_sub", FR_ZF, 1);
    chk("t2_of_sub", FR_OF, 0);
    wait_done(1, "t2_done8");
    chk("t2_r7", dut.u_regs.rf[7], 32'd1);
    chk("t2_zf_sltiu", FR_ZF, 0);

    // Variable latency store/load
    rst = 1'b0;
    clear_mem();
    i_wait = 3; d_wait = 2;
    imem[0] = i_ins(6'h08, 0, 1, 16'h1234);
    imem[1] = i_ins(6'h2B, 0, 1, 16'd8);
    imem[2] = i_ins(6'h23, 0, 5, 16'd8);
    imem[3] = j_ins(6'h02, 26'd3);
    repeat (2) @(negedge clk);
    stab_err = 0; d_req_cycles = 0;
    rst = 1'b1;
    wait_done(2, "t3_done2");
    chk("t3_dmem", dmem[2], 32'h1234);
    c0 = cycle;
    wait_done(1, "t3_done3");
    chk("t3_lw_cycles", cycle - c0, 10);
    chk("t3_r5", dut.u_regs.rf[5], 32'h1234);
    chk("t3_stable", stab_err, 0);
    chk("t3_daddr", d_last_addr, 2);
    chk("t3_dreq_cycles", d_req_cycles, 6);

    // Control flow
    rst = 1'b0;
    clear_mem();
    i_wait = 0; d_wait = 0;
    imem[0]  = i_ins(6'h08, 0, 1, 16'd1);
    imem[1]  = i_ins(6'h05, 0, 0, 16'd5);
    imem[2]  = j_ins(6'h03, 26'h10);
    imem[3]  = i_ins(6'h04, 0, 0, 16'hFFFF);
    imem[16] = i_ins(6'h08, 0, 2, 16'd3);
    imem[17] = r_ins(31, 0, 0, 0, 6'h08);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_done(2, "t4_done_bne");
    chk("t4_bne_pc", PC, 32'd8);
    wait_done(1, "t4_done_jal");
    chk("t4_jal_pc", PC, 32'h40);
    chk("t4_r31", dut.u_regs.rf[31], 32'd12);
    wait_done(1, "t4_done_addi");
    chk("t4_r2", dut.u_regs.rf[2], 32'd3);
    wait_done(1, "t4_done_jr");
    chk("t4_jr_pc", PC, 32'd12);
    wait_done(1, "t4_done_beq");
    chk("t4_beq_pc", PC, 32'd12);
    c0 = cycle;
    wait_done(1, "t4_done_beq2");
    chk("t4_beq_cycles", cycle - c0, 3);
    chk("t4_beq_zf", FR_ZF, 1);

    // Illegal opcode halts the core
    rst = 1'b0;
    clear_mem();
    imem[0] = 32'hFC00_0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 30 && !illegal; k++) @(negedge clk);
    chk("t5_illegal", illegal, 1);
    i_req_cycles = 0; d_req_cycles = 0;
    repeat (10) @(negedge clk);
    chk("t5_no_ireq", i_req_cycles, 0);
    chk("t5_no_dreq", d_req_cycles, 0);
    chk("t5_pc", PC, 32'd4);
    rst = 1'b0;
    #1;
    chk("t5_rst_pc", PC, 32'h0);
    chk("t5_rst_illegal", illegal, 0);

    // Reset during a stalled store
    clear_mem();
    imem[0] = i_ins(6'h2B, 0, 0, 16'd4);
    dmem[1] = 32'hDEAD_BEEF;
    d_wait = 1000;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 30 && !dmem_req; k++) @(negedge clk);
    chk("t6_dreq_up", dmem_req, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_dreq_drop", {dmem_req, dmem_we, imem_req}, 0);
    chk("t6_rst_pc", PC, 32'h0);
    @(negedge clk);
    d_wait = 0;
    rst = 1'b1;
    for (int k = 0; k < 20 && !imem_req; k++) @(negedge clk);
    chk("t6_refetch_req", imem_req, 1);
    chk("t6_refetch_addr", imem_addr, 0);
    chk("t6_store_abandoned", dmem[1], 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
